// File: rtl/rob_commit_pkg.sv
// Shared ROB definitions: geometry, opcode encodings and op-class helpers.
// Issue stage, reservation stations and the ROB all decode funcs through these.
package rob_commit_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int TAG_W     = 3;
    localparam int DATA_W    = 16;
    localparam int REG_W     = 4;
    localparam int FUNC_W    = 4;

    localparam logic [FUNC_W-1:0] FUNC_ADD = 4'b0000;
    localparam logic [FUNC_W-1:0] FUNC_SUB = 4'b0001;
    localparam logic [FUNC_W-1:0] FUNC_MUL = 4'b0010;
    localparam logic [FUNC_W-1:0] FUNC_DIV = 4'b0011;
    localparam logic [FUNC_W-1:0] FUNC_BEQ = 4'b0100;
    localparam logic [FUNC_W-1:0] FUNC_BNE = 4'b0101;

    typedef logic [TAG_W:0] ptr_t;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              mispred;
        logic [FUNC_W-1:0] func;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

    function automatic logic is_add(input logic [FUNC_W-1:0] f);
        return (f == FUNC_ADD) || (f == FUNC_SUB);
    endfunction

    function automatic logic is_mul(input logic [FUNC_W-1:0] f);
        return (f == FUNC_MUL) || (f == FUNC_DIV);
    endfunction

    function automatic logic is_branch(input logic [FUNC_W-1:0] f);
        return (f == FUNC_BEQ) || (f == FUNC_BNE);
    endfunction

endpackage

// File: rtl/rob_commit_storage.sv
// ROB entry array: one alloc port, one CDB port, one head read port,
// a head-retire clear and a clear-all used on branch flush.
module rob_commit_storage
    import rob_commit_pkg::*;
(
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              alloc_we,
    input  logic [TAG_W-1:0]  alloc_idx,
    input  logic [FUNC_W-1:0] alloc_func,
    input  logic [REG_W-1:0]  alloc_rd,
    input  logic              cdb_we,
    input  logic [TAG_W-1:0]  cdb_idx,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic              cdb_mispred,
    input  logic              retire_we,
    input  logic              clear_all,
    input  logic [TAG_W-1:0]  head_idx,
    output logic              head_valid,
    output logic              head_done,
    output logic              head_mispred,
    output logic [FUNC_W-1:0] head_func,
    output logic [REG_W-1:0]  head_rd,
    output logic [DATA_W-1:0] head_value
);

    rob_entry_t ent [ROB_DEPTH];

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (clear_all) begin
                    // flush wins over any CDB write landing on the same edge
                    ent[i].valid <= 1'b0;
                    ent[i].done  <= 1'b0;
                end else begin
                    if (retire_we && (head_idx == TAG_W'(i))) begin
                        ent[i].valid <= 1'b0;
                        ent[i].done  <= 1'b0;
                    end
                    if (alloc_we && (alloc_idx == TAG_W'(i))) begin
                        ent[i].valid   <= 1'b1;
                        ent[i].done    <= 1'b0;
                        ent[i].mispred <= 1'b0;
                        ent[i].func    <= alloc_func;
                        ent[i].rd      <= alloc_rd;
                    end
                    if (cdb_we && (cdb_idx == TAG_W'(i))
                        && ent[i].valid && !ent[i].done) begin
                        ent[i].done    <= 1'b1;
                        ent[i].value   <= cdb_value;
                        ent[i].mispred <= cdb_mispred;
                    end
                end
            end
        end
    end

    always_comb begin
        head_valid   = ent[head_idx].valid;
        head_done    = ent[head_idx].done;
        head_mispred = ent[head_idx].mispred;
        head_func    = ent[head_idx].func;
        head_rd      = ent[head_idx].rd;
        head_value   = ent[head_idx].value;
    end

endmodule

// File: rtl/rob_commit.sv
// ROB pointers, in-order commit and flush decision, registered
// register-file write and RS free pulses toward regbank and the RS.
module rob_commit
    import rob_commit_pkg::*;
(
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic [FUNC_W-1:0] alloc_func,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic              cdb_mispred,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [TAG_W-1:0]  rf_tag,
    output logic              add_free,
    output logic              mul_free,
    output logic              bch_free,
    output logic              flush,
    output logic [TAG_W:0]    rob_count
);

    ptr_t head;
    ptr_t tail;

    logic [TAG_W-1:0]  head_idx;
    logic              h_valid;
    logic              h_done;
    logic              h_mis;
    logic [FUNC_W-1:0] h_func;
    logic [REG_W-1:0]  h_rd;
    logic [DATA_W-1:0] h_value;

    logic full;
    logic commit;
    logic flush_now;
    logic alloc_fire;

    logic nxt_we;
    logic nxt_add;
    logic nxt_mul;
    logic nxt_bch;

    assign head_idx  = head[TAG_W-1:0];
    assign alloc_tag = tail[TAG_W-1:0];
    assign rob_count = tail - head;

    rob_commit_storage u_storage (
        .clk1         (clk1),
        .rst_n        (rst_n),
        .alloc_we     (alloc_fire),
        .alloc_idx    (tail[TAG_W-1:0]),
        .alloc_func   (alloc_func),
        .alloc_rd     (alloc_rd),
        .cdb_we       (cdb_valid),
        .cdb_idx      (cdb_tag),
        .cdb_value    (cdb_value),
        .cdb_mispred  (cdb_mispred),
        .retire_we    (commit),
        .clear_all    (flush_now),
        .head_idx     (head_idx),
        .head_valid   (h_valid),
        .head_done    (h_done),
        .head_mispred (h_mis),
        .head_func    (h_func),
        .head_rd      (h_rd),
        .head_value   (h_value)
    );

    always_comb begin
        full = (head[TAG_W-1:0] == tail[TAG_W-1:0])
            && (head[TAG_W] != tail[TAG_W]);
        commit      = h_valid && h_done;
        flush_now   = commit && is_branch(h_func) && h_mis;
        alloc_ready = !full && !flush_now;
        alloc_fire  = alloc_valid && alloc_ready;
    end

    always_comb begin
        nxt_we  = 1'b0;
        nxt_add = 1'b0;
        nxt_mul = 1'b0;
        nxt_bch = 1'b0;
        if (commit) begin
            unique case (1'b1)
                is_add(h_func): begin
                    nxt_we  = 1'b1;
                    nxt_add = 1'b1;
                end
                is_mul(h_func): begin
                    nxt_we  = 1'b1;
                    nxt_mul = 1'b1;
                end
                is_branch(h_func): begin
                    nxt_bch = 1'b1;
                end
                default: begin
                    nxt_we = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (commit) begin
                head <= head + ptr_t'(1);
            end
            // a flush leaves the ROB empty just past the retiring branch
            if (flush_now) begin
                tail <= head + ptr_t'(1);
            end else if (alloc_fire) begin
                tail <= tail + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
            rf_tag   <= '0;
            add_free <= 1'b0;
            mul_free <= 1'b0;
            bch_free <= 1'b0;
            flush    <= 1'b0;
        end else begin
            rf_we    <= nxt_we;
            add_free <= nxt_add;
            mul_free <= nxt_mul;
            bch_free <= nxt_bch;
            flush    <= flush_now;
            if (commit) begin
                rf_rd    <= h_rd;
                rf_wdata <= h_value;
                rf_tag   <= head_idx;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboarded bench for rob_commit: expected retirements queued at
// stimulus time, popped and compared whenever a commit pulse appears.
module tb_rob_commit;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        alloc_valid;
    logic [3:0]  alloc_func;
    logic [3:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_value;
    logic        cdb_mispred;
    logic        rf_we;
    logic [3:0]  rf_rd;
    logic [15:0] rf_wdata;
    logic [2:0]  rf_tag;
    logic        add_free;
    logic        mul_free;
    logic        bch_free;
    logic        flush;
    logic [3:0]  rob_count;

    localparam logic [3:0] F_ADD = 4'b0000;
    localparam logic [3:0] F_SUB = 4'b0001;
    localparam logic [3:0] F_MUL = 4'b0010;
    localparam logic [3:0] F_DIV = 4'b0011;
    localparam logic [3:0] F_BEQ = 4'b0100;
    localparam logic [3:0] F_BNE = 4'b0101;
    localparam logic [3:0] F_OTH = 4'b1000;

    typedef struct {
        logic        we;
        logic [3:0]  rd;
        logic [15:0] val;
        logic [2:0]  tag;
        logic        add;
        logic        mul;
        logic        bch;
        logic        fl;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk1 = ~clk1;

    rob_commit dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .alloc_valid (alloc_valid),
        .alloc_func  (alloc_func),
        .alloc_rd    (alloc_rd),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value),
        .cdb_mispred (cdb_mispred),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata),
        .rf_tag      (rf_tag),
        .add_free    (add_free),
        .mul_free    (mul_free),
        .bch_free    (bch_free),
        .flush       (flush),
        .rob_count   (rob_count)
    );

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, obs, exp);
        end
    endtask

    task automatic expect_c(input logic [3:0] f, input logic [3:0] rd,
                            input logic [15:0] v, input logic [2:0] tag,
                            input logic mis);
        exp_t e;
        e.rd  = rd;
        e.val = v;
        e.tag = tag;
        e.add = (f == F_ADD) || (f == F_SUB);
        e.mul = (f == F_MUL) || (f == F_DIV);
        e.bch = (f == F_BEQ) || (f == F_BNE);
        e.we  = !e.bch;
        e.fl  = e.bch && mis;
        sbq.push_back(e);
    endtask

    exp_t cur;
    always @(negedge clk1) begin
        if (rst_n && (rf_we || add_free || mul_free || bch_free || flush)) begin
            if (sbq.size() == 0) begin
                chk("sb_extra", 32'd1, 32'd0);
            end else begin
                cur = sbq.pop_front();
                chk("rf_we", 32'(rf_we), 32'(cur.we));
                if (cur.we) begin
                    chk("rf_rd", 32'(rf_rd), 32'(cur.rd));
                    chk("rf_wdata", 32'(rf_wdata), 32'(cur.val));
                    chk("rf_tag", 32'(rf_tag), 32'(cur.tag));
                end
                chk("add_free", 32'(add_free), 32'(cur.add));
                chk("mul_free", 32'(mul_free), 32'(cur.mul));
                chk("bch_free", 32'(bch_free), 32'(cur.bch));
                chk("flush", 32'(flush), 32'(cur.fl));
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic do_alloc(input logic [3:0] f, input logic [3:0] rd);
        alloc_valid = 1'b1;
        alloc_func  = f;
        alloc_rd    = rd;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_cdb(input logic [2:0] tag, input logic [15:0] v,
                          input logic mis);
        cdb_valid   = 1'b1;
        cdb_tag     = tag;
        cdb_value   = v;
        cdb_mispred = mis;
        tick();
        cdb_valid   = 1'b0;
        cdb_mispred = 1'b0;
    endtask

    logic [3:0] ftab [6];

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] t;
        ftab[0] = F_ADD;
        ftab[1] = F_MUL;
        ftab[2] = F_OTH;
        ftab[3] = F_SUB;
        ftab[4] = F_BNE;
        ftab[5] = F_DIV;
        alloc_valid = 1'b0;
        alloc_func  = '0;
        alloc_rd    = '0;
        cdb_valid   = 1'b0;
        cdb_tag     = '0;
        cdb_value   = '0;
        cdb_mispred = 1'b0;
        do_reset();

        // reset asserted mid-traffic
        do_alloc(F_ADD, 4'd1);
        do_alloc(F_MUL, 4'd2);
        do_alloc(F_ADD, 4'd3);
        do_cdb(3'd2, 16'h0777, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("rst_count", 32'(rob_count), 32'd0);
        chk("rst_tag", 32'(alloc_tag), 32'd0);
        chk("rst_ready", 32'(alloc_ready), 32'd1);
        chk("rst_outs", 32'({rf_we, add_free, mul_free, bch_free, flush}), 32'd0);
        chk("rst_rf", 32'({rf_rd, rf_wdata, rf_tag}), 32'd0);
        idle(1);
        rst_n = 1'b1;
        idle(1);

        // fill, dropped alloc, full-with-commit
        for (int i = 0; i < 8; i++) do_alloc(F_ADD, 4'(i));
        chk("fill_ready", 32'(alloc_ready), 32'd0);
        chk("fill_count", 32'(rob_count), 32'd8);
        chk("fill_tag", 32'(alloc_tag), 32'd0);
        do_alloc(F_MUL, 4'd15);
        chk("drop_count", 32'(rob_count), 32'd8);
        chk("drop_tag", 32'(alloc_tag), 32'd0);
        expect_c(F_ADD, 4'd0, 16'h0100, 3'd0, 1'b0);
        do_cdb(3'd0, 16'h0100, 1'b0);
        alloc_valid = 1'b1;
        alloc_func  = F_ADD;
        alloc_rd    = 4'd9;
        chk("sim_ready0", 32'(alloc_ready), 32'd0);
        tick();
        chk("sim_count7", 32'(rob_count), 32'd7);
        chk("sim_ready1", 32'(alloc_ready), 32'd1);
        tick();
        alloc_valid = 1'b0;
        chk("sim_count8", 32'(rob_count), 32'd8);
        for (int i = 1; i < 8; i++) begin
            expect_c(F_ADD, 4'(i), 16'h0100 + 16'(i), 3'(i), 1'b0);
            do_cdb(3'(i), 16'h0100 + 16'(i), 1'b0);
        end
        expect_c(F_ADD, 4'd9, 16'h01AA, 3'd0, 1'b0);
        do_cdb(3'd0, 16'h01AA, 1'b0);
        idle(3);
        chk("drain_count", 32'(rob_count), 32'd0);

        // out-of-order completion
        do_reset();
        do_alloc(F_ADD, 4'd1);
        do_alloc(F_MUL, 4'd2);
        expect_c(F_ADD, 4'd1, 16'h0005, 3'd0, 1'b0);
        expect_c(F_MUL, 4'd2, 16'h0030, 3'd1, 1'b0);
        do_cdb(3'd1, 16'h0030, 1'b0);
        do_cdb(3'd0, 16'h0005, 1'b0);
        chk("ooo_nobypass", 32'(rf_we), 32'd0);
        tick();
        chk("ooo_tag0", 32'({rf_we, add_free, rf_tag}), 32'({2'b11, 3'd0}));
        tick();
        chk("ooo_tag1", 32'({rf_we, mul_free, rf_tag}), 32'({2'b11, 3'd1}));
        tick();
        chk("ooo_idle", 32'(rf_we), 32'd0);

        // mispredicted branch
        do_reset();
        do_alloc(F_BEQ, 4'd0);
        do_alloc(F_ADD, 4'd3);
        do_alloc(F_ADD, 4'd4);
        expect_c(F_BEQ, 4'd0, 16'h0000, 3'd0, 1'b1);
        do_cdb(3'd1, 16'h0011, 1'b0);
        do_cdb(3'd0, 16'h0000, 1'b1);
        chk("mp_ready0", 32'(alloc_ready), 32'd0);
        chk("mp_count3", 32'(rob_count), 32'd3);
        tick();
        chk("mp_pulse", 32'({flush, bch_free, rf_we}), 32'b110);
        chk("mp_count0", 32'(rob_count), 32'd0);
        chk("mp_ready1", 32'(alloc_ready), 32'd1);
        chk("mp_tag", 32'(alloc_tag), 32'd1);
        idle(3);
        expect_c(F_ADD, 4'd5, 16'h0055, 3'd1, 1'b0);
        do_alloc(F_ADD, 4'd5);
        do_cdb(3'd1, 16'h0055, 1'b0);
        idle(2);

        // wrap, duplicate and empty-tag CDB
        do_reset();
        for (int k = 0; k < 20; k++) begin
            t = 3'(k);
            expect_c(ftab[k % 6], 4'(k), 16'h0200 + 16'(k), t, 1'b0);
            do_alloc(ftab[k % 6], 4'(k));
            do_cdb(t, 16'h0200 + 16'(k), 1'b0);
            do_cdb(t, 16'hBEEF, 1'b0);
            do_cdb(3'(t + 3'd1), 16'hDEAD, 1'b0);
        end
        idle(2);
        chk("wrap_count", 32'(rob_count), 32'd0);
        chk("wrap_tag", 32'(alloc_tag), 32'd4);

        idle(3);
        chk("sb_left", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
